// File: rtl/cpu_core_mc.sv
// Multi-cycle fetch/decode/execute/writeback core with an N-entry register file.
// Optional flag outputs are built only when CPU_CORE_FLAGS_EN is defined.
module cpu_core_mc #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 4,
    localparam int REG_SEL_W = $clog2(NUM_REGS),
    localparam int INSTR_W   = 4 + 2 * REG_SEL_W
) (
    input  logic                 clock_pulse,
    input  logic                 reset,
    input  logic                 instr_valid,
    input  logic [INSTR_W-1:0]   instr,
    output logic                 instr_ready,
    output logic                 retire,
    output logic [1:0]           state,
    input  logic [REG_SEL_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]    dbg_data,
    output logic                 flag_zero,
    output logic                 flag_carry
);

    localparam logic [1:0] S_FETCH     = 2'b00;
    localparam logic [1:0] S_DECODE    = 2'b01;
    localparam logic [1:0] S_EXECUTE   = 2'b10;
    localparam logic [1:0] S_WRITEBACK = 2'b11;
    localparam logic [DATA_W-1:0] ONE  = 1;

    logic [1:0]           r_state;
    logic [INSTR_W-1:0]   r_ir;
    logic                 r_retire;
    logic                 r_mode;
    logic [2:0]           r_opcode;
    logic [REG_SEL_W-1:0] r_rega;
    logic [REG_SEL_W-1:0] r_regb;
    logic [DATA_W-1:0]    r_opa;
    logic [DATA_W-1:0]    r_opb;
    logic [DATA_W-1:0]    r_result;
    logic [DATA_W-1:0]    r_regs [NUM_REGS];

    logic [REG_SEL_W-1:0] w_ir_rega;
    logic [REG_SEL_W-1:0] w_ir_regb;
    logic                 w_is_nop;
    logic [DATA_W-1:0]    w_ldi_value;
    logic [DATA_W-1:0]    w_alu_result;

    // Handshake: an instruction transfers on a rising edge where instr_valid
    // and instr_ready are both high; instr_ready is high exactly in FETCH.
    assign instr_ready = (r_state == S_FETCH);
    assign retire      = r_retire;
    assign state       = r_state;
    assign dbg_data    = r_regs[dbg_sel];

    assign w_ir_rega   = r_ir[2*REG_SEL_W-1 -: REG_SEL_W];
    assign w_ir_regb   = r_ir[REG_SEL_W-1:0];
    assign w_is_nop    = !r_mode && (r_opcode == 3'b000);
    assign w_ldi_value = {{(DATA_W-3-REG_SEL_W){1'b0}}, r_opcode, r_regb};

    always_comb begin
        w_alu_result = '0;
        if (r_mode) begin
            w_alu_result = w_ldi_value;
        end else begin
            case (r_opcode)
                3'b001:  w_alu_result = r_opa + r_opb;
                3'b010:  w_alu_result = r_opa - r_opb;
                3'b011:  w_alu_result = r_opa + ONE;
                3'b100:  w_alu_result = r_opa - ONE;
                3'b101:  w_alu_result = r_opa & r_opb;
                3'b110:  w_alu_result = r_opa | r_opb;
                3'b111:  w_alu_result = r_opb;
                default: w_alu_result = '0;
            endcase
        end
    end

    always_ff @(posedge clock_pulse) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_ir     <= '0;
            r_retire <= 1'b0;
            r_mode   <= 1'b0;
            r_opcode <= '0;
            r_rega   <= '0;
            r_regb   <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (instr_valid) begin
                        r_ir    <= instr;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Both operands come from the pre-instruction register file,
                    // so regA==regB reads the same value twice.
                    r_mode   <= r_ir[INSTR_W-1];
                    r_opcode <= r_ir[INSTR_W-2 -: 3];
                    r_rega   <= w_ir_rega;
                    r_regb   <= w_ir_regb;
                    r_opa    <= r_regs[w_ir_rega];
                    r_opb    <= r_regs[w_ir_regb];
                    r_state  <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    r_result <= w_alu_result;
                    r_state  <= S_WRITEBACK;
                end
                default: begin
                    if (!w_is_nop) r_regs[r_rega] <= r_result;
                    r_retire <= 1'b1;
                    r_state  <= S_FETCH;
                end
            endcase
        end
    end

`ifdef CPU_CORE_FLAGS_EN
    logic [DATA_W:0] w_add_ext;
    logic            w_alu_carry;
    logic            r_res_zero;
    logic            r_res_carry;
    logic            r_flag_zero;
    logic            r_flag_carry;

    assign w_add_ext = {1'b0, r_opa} + {1'b0, r_opb};

    always_comb begin
        w_alu_carry = 1'b0;
        if (!r_mode) begin
            case (r_opcode)
                3'b001:  w_alu_carry = w_add_ext[DATA_W];
                3'b010:  w_alu_carry = (r_opa < r_opb);
                3'b011:  w_alu_carry = &r_opa;
                3'b100:  w_alu_carry = (r_opa == '0);
                default: w_alu_carry = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock_pulse) begin
        if (reset) begin
            r_res_zero   <= 1'b0;
            r_res_carry  <= 1'b0;
            r_flag_zero  <= 1'b0;
            r_flag_carry <= 1'b0;
        end else if (r_state == S_EXECUTE) begin
            r_res_zero  <= (w_alu_result == '0);
            r_res_carry <= w_alu_carry;
        end else if ((r_state == S_WRITEBACK) && !w_is_nop) begin
            r_flag_zero  <= r_res_zero;
            r_flag_carry <= r_res_carry;
        end
    end

    assign flag_zero  = r_flag_zero;
    assign flag_carry = r_flag_carry;
`else
    assign flag_zero  = 1'b0;
    assign flag_carry = 1'b0;
`endif

endmodule
